// File: rtl/io_handshake_responder.sv
// Peripheral side of the core's stall-on-I/O handshake: holds rdy high while an
// `output`/`input` instruction waits for a debounced confirm press from the user.
module io_handshake_responder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SW_WIDTH        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_out_req,
  input  logic                io_in_req,
  input  logic [31:0]         out_data,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                btn_confirm,
  output logic                rdy,
  output logic [31:0]         in_data,
  output logic [31:0]         disp_value,
  output logic                disp_valid,
  output logic [15:0]         io_count
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StOutWait = 2'd1;
  localparam logic [1:0] StInWait  = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  logic                btn_sync1_q, btn_sync2_q;
  logic [SW_WIDTH-1:0] sw_sync1_q, sw_sync2_q;
  logic                level_q, level_d;
  logic [CntW-1:0]     db_cnt_q, db_cnt_d;
  logic [CntW-1:0]     rel_cnt_q, rel_cnt_d;
  logic                armed_q, armed_d;
  logic [1:0]          state_q, state_d;
  logic [31:0]         in_data_q, in_data_d;
  logic [31:0]         disp_value_q, disp_value_d;
  logic                disp_valid_q, disp_valid_d;
  logic [15:0]         io_count_q, io_count_d;
  logic                flip;
  logic                press_evt;
  logic                zero_stable;

  // Debounce: count consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    flip     = 1'b0;
    if (btn_sync2_q != level_q) begin
      if (db_cnt_q == CntMax) begin
        flip    = 1'b1;
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + CntW'(1);
      end
    end
  end

  // Arming needs a debounced release, so a button held through reset never counts.
  always_comb begin
    rel_cnt_d = rel_cnt_q;
    if (btn_sync2_q) begin
      rel_cnt_d = '0;
    end else if (rel_cnt_q != CntMax) begin
      rel_cnt_d = rel_cnt_q + CntW'(1);
    end
    zero_stable = ~btn_sync2_q & (rel_cnt_q == CntMax);
    press_evt   = flip & ~level_q & armed_q;
    armed_d     = press_evt ? 1'b0 : (armed_q | zero_stable);
  end

  always_comb begin
    state_d      = state_q;
    in_data_d    = in_data_q;
    disp_value_d = disp_value_q;
    disp_valid_d = disp_valid_q;
    io_count_d   = io_count_q;
    case (state_q)
      StIdle: begin
        if (io_in_req) begin
          state_d = StInWait;
        end else if (io_out_req) begin
          state_d      = StOutWait;
          disp_value_d = out_data;
          disp_valid_d = 1'b1;
        end
      end
      StOutWait: begin
        if (press_evt) state_d = StDone;
      end
      StInWait: begin
        if (press_evt) begin
          state_d   = StDone;
          in_data_d = 32'(sw_sync2_q);
        end
      end
      StDone: begin
        state_d    = StIdle;
        io_count_d = io_count_q + 16'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Zero-latency stall: the core must not advance past an unserved request.
  always_comb begin
    rdy = 1'b0;
    if (!reset) begin
      case (state_q)
        StOutWait, StInWait: rdy = 1'b1;
        StIdle:              rdy = io_in_req | io_out_req;
        default:             rdy = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync1_q  <= 1'b0;
      btn_sync2_q  <= 1'b0;
      sw_sync1_q   <= '0;
      sw_sync2_q   <= '0;
      level_q      <= 1'b0;
      db_cnt_q     <= '0;
      rel_cnt_q    <= '0;
      armed_q      <= 1'b0;
      state_q      <= StIdle;
      in_data_q    <= '0;
      disp_value_q <= '0;
      disp_valid_q <= 1'b0;
      io_count_q   <= '0;
    end else begin
      btn_sync1_q  <= btn_confirm;
      btn_sync2_q  <= btn_sync1_q;
      sw_sync1_q   <= switches;
      sw_sync2_q   <= sw_sync1_q;
      level_q      <= level_d;
      db_cnt_q     <= db_cnt_d;
      rel_cnt_q    <= rel_cnt_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      in_data_q    <= in_data_d;
      disp_value_q <= disp_value_d;
      disp_valid_q <= disp_valid_d;
      io_count_q   <= io_count_d;
    end
  end

  assign in_data    = in_data_q;
  assign disp_value = disp_value_q;
  assign disp_valid = disp_valid_q;
  assign io_count   = io_count_q;

endmodule

// File: tb/tb_io_handshake_responder.sv
// Bench for io_handshake_responder: directed scenarios plus random traffic, all
// checked every cycle against a run-length based behavioural model.
module tb_io_handshake_responder;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_out_req;
  logic        io_in_req;
  logic [31:0] out_data;
  logic [15:0] switches;
  logic        btn_confirm;
  logic        rdy;
  logic [31:0] in_data;
  logic [31:0] disp_value;
  logic        disp_valid;
  logic [15:0] io_count;

  always #5 clk = ~clk;

  io_handshake_responder #(
    .DEBOUNCE_CYCLES(D),
    .SW_WIDTH       (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .io_out_req (io_out_req),
    .io_in_req  (io_in_req),
    .out_data   (out_data),
    .switches   (switches),
    .btn_confirm(btn_confirm),
    .rdy        (rdy),
    .in_data    (in_data),
    .disp_value (disp_value),
    .disp_valid (disp_valid),
    .io_count   (io_count)
  );

  // Model state: mode 0 idle, 1 waiting for output ack, 2 waiting for input, 3 retire.
  int          ones_run, zeros_run, m_mode;
  bit          m_level, m_armed, m_live, ms1, ms2, m_dv, m_evt;
  logic [15:0] msw1, msw2, m_cnt;
  logic [31:0] m_in, m_disp;
  bit          preset_req;

  initial begin
    m_live = 0; ones_run = 0; zeros_run = 0; m_mode = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_live = 1; ms1 = 0; ms2 = 0; msw1 = 0; msw2 = 0;
        m_level = 0; m_armed = 0; ones_run = 0; zeros_run = 0;
        m_mode = 0; m_in = 0; m_disp = 0; m_dv = 0; m_cnt = 0;
      end else if (m_live) begin
        if (ms2) begin
          if (ones_run < 1000) ones_run++;
          zeros_run = 0;
        end else begin
          if (zeros_run < 1000) zeros_run++;
          ones_run = 0;
        end
        // A press counts once D high samples follow a debounced release.
        m_evt = m_armed && !m_level && ones_run == D;
        if (!m_level && ones_run == D) m_level = 1;
        else if (m_level && zeros_run == D) m_level = 0;
        if (zeros_run >= D) m_armed = 1;
        if (m_evt) m_armed = 0;
        case (m_mode)
          0: begin
            if (io_in_req) m_mode = 2;
            else if (io_out_req) begin
              m_mode = 1; m_disp = out_data; m_dv = 1;
            end
          end
          1: if (m_evt) m_mode = 3;
          2: if (m_evt) begin m_mode = 3; m_in = {16'h0000, msw2}; end
          default: begin m_mode = 0; m_cnt = m_cnt + 16'd1; end
        endcase
        ms2 = ms1; ms1 = btn_confirm; msw2 = msw1; msw1 = switches;
        if (preset_req) m_cnt = 16'hFFFF;
      end
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [4:0]  pin_mask;
  logic [31:0] pin_val [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic exp_rdy;
    forever begin
      @(negedge clk);
      if (m_live) begin
        exp_rdy = !reset && (m_mode == 1 || m_mode == 2 ||
                             (m_mode == 0 && (io_in_req || io_out_req)));
        chk("rdy", {31'd0, rdy}, {31'd0, exp_rdy});
        chk("in_data", in_data, m_in);
        chk("disp_value", disp_value, m_disp);
        chk("disp_valid", {31'd0, disp_valid}, {31'd0, m_dv});
        chk("io_count", {16'd0, io_count}, {16'd0, m_cnt});
        if (pin_mask[0]) chk("pin_rdy", {31'd0, rdy}, pin_val[0]);
        if (pin_mask[1]) chk("pin_in_data", in_data, pin_val[1]);
        if (pin_mask[2]) chk("pin_disp_value", disp_value, pin_val[2]);
        if (pin_mask[3]) chk("pin_disp_valid", {31'd0, disp_valid}, pin_val[3]);
        if (pin_mask[4]) chk("pin_io_count", {16'd0, io_count}, pin_val[4]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    pin_mask = '0;
  endtask

  task automatic pin(input int idx, input logic [31:0] v);
    pin_mask[idx] = 1'b1;
    pin_val[idx]  = v;
  endtask

  task automatic press(input int hold, input int rel);
    btn_confirm = 1'b1;
    repeat (hold) step();
    btn_confirm = 1'b0;
    repeat (rel) step();
  endtask

  initial begin
    int run_left;
    pin_mask = '0; preset_req = 0; run_left = 0;
    reset = 1; io_out_req = 1; io_in_req = 0; out_data = 32'hDEAD;
    switches = '0; btn_confirm = 0;
    step(); step();
    // Reset dominates the forced display request.
    pin(0, 0); pin(2, 0); pin(3, 0); step();
    reset = 0;
    pin(0, 1); step();
    pin(2, 32'hDEAD); pin(3, 1); pin(0, 1); io_out_req = 0; step();
    repeat (6) step();
    press(8, 8);
    pin(4, 1); step();

    // Output with a long held press: exactly one retire, no second event.
    out_data = 32'h12345678; io_out_req = 1; step();
    io_out_req = 0; btn_confirm = 1;
    repeat (6) step();
    pin(0, 0); pin(2, 32'h12345678); pin(4, 1); step();
    pin(4, 2); step();
    out_data = 32'h1111; io_out_req = 1; step();
    io_out_req = 0;
    repeat (10) step();
    pin(0, 1); step();
    btn_confirm = 0; repeat (8) step();
    press(8, 8);
    pin(2, 32'h1111); pin(4, 3); step();

    // Input capture, then switches move after retire.
    switches = 16'hA5C3; io_in_req = 1; step();
    io_in_req = 0; btn_confirm = 1;
    repeat (6) step();
    pin(1, 32'h0000A5C3); pin(0, 0); step();
    switches = 16'hFFFF; btn_confirm = 0;
    repeat (8) step();
    pin(1, 32'h0000A5C3); pin(4, 4); step();

    // Short glitches must not complete the transaction.
    io_in_req = 1; step();
    io_in_req = 0;
    repeat (5) begin
      btn_confirm = 1; repeat (3) step();
      btn_confirm = 0; repeat (3) step();
    end
    pin(0, 1); step();
    press(8, 8);
    pin(1, 32'h0000FFFF); pin(4, 5); step();

    // Reset mid-input with the button held through it.
    io_in_req = 1; step();
    io_in_req = 0; btn_confirm = 1; step(); step();
    reset = 1; step();
    reset = 0;
    pin(0, 0); pin(1, 0); pin(4, 0); step();
    io_in_req = 1; step();
    io_in_req = 0;
    repeat (10) step();
    pin(0, 1); step();
    btn_confirm = 0; repeat (8) step();
    btn_confirm = 1; repeat (6) step();
    pin(0, 0); step();
    btn_confirm = 0; repeat (8) step();
    pin(4, 1); step();

    // Counter wrap and input priority over output.
    preset_req = 1;
    @(posedge clk);
    #1 force dut.io_count_q = 16'hFFFF;
    #1 release dut.io_count_q;
    preset_req = 0; pin_mask = '0;
    pin(4, 16'hFFFF); step();
    out_data = 32'hBEEF; switches = 16'h1234; io_in_req = 1; io_out_req = 1; step();
    io_in_req = 0; io_out_req = 0; btn_confirm = 1;
    repeat (6) step();
    pin(0, 0); pin(2, 0); pin(3, 0); step();
    pin(4, 0); pin(1, 32'h00001234); step();
    btn_confirm = 0; repeat (8) step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if (run_left == 0) begin
        btn_confirm = 1'($urandom_range(0, 1));
        run_left    = $urandom_range(1, 9);
      end
      run_left--;
      io_in_req  = ($urandom_range(0, 7) == 0);
      io_out_req = ($urandom_range(0, 5) == 0);
      out_data   = $urandom;
      switches   = 16'($urandom);
      reset      = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 0; io_in_req = 0; io_out_req = 0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
